// File: rtl/frame_update_scheduler.sv
// Frame-synchronous round-robin scheduler granting game-logic requesters
// one at a time during vertical blank, with per-grant timeout and abort.
module frame_update_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             i_pix_clk,
    input  logic             i_rst_n,
    input  logic             i_frame,
    input  logic             i_de,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_done,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_busy,
    output logic             o_cycle_done,
    output logic             o_abort,
    output logic [N_REQ-1:0] o_timeout_err,
    output logic             o_overrun
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARB   = 2'd1;
    localparam logic [1:0] S_GRANT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [PW-1:0]    last_ptr_q, last_ptr_d;
    logic [PW-1:0]    gidx_q, gidx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             cycle_done_q, cycle_done_d;
    logic             abort_q, abort_d;
    logic             overrun_q, overrun_d;
    logic [N_REQ-1:0] terr_q, terr_d;
    logic             de_q, de_d;

    logic             de_rise;
    logic             hi_found, lo_found;
    logic [PW-1:0]    hi_sel, lo_sel, sel;

    assign de_d    = i_de;
    assign de_rise = i_de & ~de_q;

    // Lowest pending index above last_ptr wins; otherwise wrap to the lowest overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pending_q[i]) begin
                if (i > int'(last_ptr_q)) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_sel   = PW'(i);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_sel   = PW'(i);
                end
            end
        end
        sel = hi_found ? hi_sel : lo_sel;
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        last_ptr_d   = last_ptr_q;
        gidx_d       = gidx_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        terr_d       = terr_q;
        cycle_done_d = 1'b0;
        abort_d      = 1'b0;
        overrun_d    = i_frame && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (i_frame) begin
                    pending_d = i_req;
                    state_d   = S_ARB;
                end
            end
            S_ARB: begin
                if (de_rise) begin
                    pending_d = '0;
                    grant_d   = '0;
                    abort_d   = 1'b1;
                    state_d   = S_IDLE;
                end else if (pending_q == '0) begin
                    cycle_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    gidx_d       = sel;
                    cnt_d        = '0;
                    state_d      = S_GRANT;
                end
            end
            S_GRANT: begin
                if (de_rise) begin
                    pending_d = '0;
                    grant_d   = '0;
                    abort_d   = 1'b1;
                    state_d   = S_IDLE;
                end else if (i_done[gidx_q]) begin
                    grant_d           = '0;
                    pending_d[gidx_q] = 1'b0;
                    last_ptr_d        = gidx_q;
                    state_d           = S_ARB;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    grant_d           = '0;
                    pending_d[gidx_q] = 1'b0;
                    terr_d[gidx_q]    = 1'b1;
                    last_ptr_d        = gidx_q;
                    state_d           = S_ARB;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            last_ptr_q   <= PW'(N_REQ - 1);
            gidx_q       <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            cycle_done_q <= 1'b0;
            abort_q      <= 1'b0;
            overrun_q    <= 1'b0;
            terr_q       <= '0;
            de_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            last_ptr_q   <= last_ptr_d;
            gidx_q       <= gidx_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            cycle_done_q <= cycle_done_d;
            abort_q      <= abort_d;
            overrun_q    <= overrun_d;
            terr_q       <= terr_d;
            de_q         <= de_d;
        end
    end

    assign o_grant       = grant_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_cycle_done  = cycle_done_q;
    assign o_abort       = abort_q;
    assign o_overrun     = overrun_q;
    assign o_timeout_err = terr_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Scoreboard bench for frame_update_scheduler: grant order, timeout,
// abort, overrun and asynchronous reset behaviour.
module tb_frame_update_scheduler;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         frame = 1'b0;
    logic         de    = 1'b0;
    logic [N-1:0] req   = '0;
    logic [N-1:0] done  = '0;
    logic [N-1:0] o_grant;
    logic         o_busy;
    logic         o_cycle_done;
    logic         o_abort;
    logic [N-1:0] o_timeout_err;
    logic         o_overrun;

    int n_checks = 0;
    int n_errors = 0;
    int n_cdone  = 0;
    int n_abort  = 0;
    int n_ovr    = 0;

    logic [N-1:0] exp_q[$];
    logic [N-1:0] prev_g = '0;
    int           resp_delay = 3;
    logic [N-1:0] never_mask = '0;

    frame_update_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .i_pix_clk    (clk),
        .i_rst_n      (rst_n),
        .i_frame      (frame),
        .i_de         (de),
        .i_req        (req),
        .i_done       (done),
        .o_grant      (o_grant),
        .o_busy       (o_busy),
        .o_cycle_done (o_cycle_done),
        .o_abort      (o_abort),
        .o_timeout_err(o_timeout_err),
        .o_overrun    (o_overrun)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame(input logic [N-1:0] r);
        req   = r;
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    task automatic wait_grant(input logic [N-1:0] g, input string tag);
        int n;
        n = 0;
        while (o_grant !== g && n < 100) begin
            tick();
            n++;
        end
        check(tag, o_grant, g);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (o_busy && n < 400) begin
            tick();
            n++;
        end
        check(tag, o_busy, 0);
        tick();
    endtask

    task automatic measure_hold(input logic [N-1:0] g, output int hold);
        hold = 0;
        while (o_grant == g && hold < 40) begin
            hold++;
            tick();
        end
    endtask

    // Per-cycle invariants, pulse counters and in-order grant scoreboard
    always @(negedge clk) begin
        check("onehot0", 32'($onehot0(o_grant)), 1);
        check("busy_vs_state", o_busy, 32'(dut.state_q != 2'd0));
        if (o_cycle_done) n_cdone <= n_cdone + 1;
        if (o_abort)      n_abort <= n_abort + 1;
        if (o_overrun)    n_ovr   <= n_ovr + 1;
        if (o_grant != '0 && prev_g == '0) begin
            if (exp_q.size() == 0) check("grant_unexpected", o_grant, 0);
            else                   check("grant_order", o_grant, exp_q.pop_front());
        end
        prev_g <= o_grant;
    end

    // Requester model: answers done resp_delay cycles after its grant appears
    initial begin
        logic [N-1:0] last_g;
        int           cnt;
        last_g = '0;
        cnt    = 0;
        forever begin
            @(posedge clk);
            #1;
            done = '0;
            if (o_grant != '0) begin
                cnt = (o_grant == last_g) ? cnt + 1 : 0;
                if ((o_grant & never_mask) == '0 && cnt == resp_delay)
                    done = o_grant;
            end
            last_g = o_grant;
        end
    end

    initial begin
        int c0, a0, v0, hold, seen;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_grant", o_grant, 0);
        check("rst_busy", o_busy, 0);
        check("rst_terr", o_timeout_err, 0);
        check("rst_pulses", {o_cycle_done, o_abort, o_overrun}, 0);
        rst_n = 1'b1;
        tick();

        // basic sequence 1011, done three cycles after each grant
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b1000);
        c0 = n_cdone;
        pulse_frame(4'b1011);
        check("lat_arb_busy", o_busy, 1);
        check("lat_arb_grant", o_grant, 0);
        tick();
        check("lat_first_grant", o_grant, 4'b0001);
        wait_idle("basic_idle");
        check("basic_cycle_done", n_cdone - c0, 1);
        check("basic_sb_empty", exp_q.size(), 0);

        // fairness: last served 3, so next frame starts at 0
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        pulse_frame(4'b1111);
        wait_idle("fair_idle");
        check("fair_sb_empty", exp_q.size(), 0);

        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        a0 = n_abort;
        pulse_frame(4'b1111);
        wait_grant(4'b0010, "fair_wait_g1");
        de = 1'b1;
        tick();
        de = 1'b0;
        check("fair_abort_pulse", o_abort, 1);
        check("fair_abort_grant", o_grant, 0);
        check("fair_abort_busy", o_busy, 0);
        tick();
        check("fair_abort_count", n_abort - a0, 1);

        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        pulse_frame(4'b1111);
        wait_idle("fair2_idle");
        check("fair2_sb_empty", exp_q.size(), 0);

        // abort while 0010 granted, 0100 still pending
        exp_q.push_back(4'b0010);
        pulse_frame(4'b0110);
        wait_grant(4'b0010, "abort_wait");
        de = 1'b1;
        tick();
        de = 1'b0;
        check("abort_pulse", o_abort, 1);
        check("abort_grant", o_grant, 0);
        check("abort_busy", o_busy, 0);
        repeat (20) tick();
        check("abort_no_req2", o_grant, 0);
        check("abort_sb_empty", exp_q.size(), 0);

        // timeout: requester 2 never answers, 3 still served
        never_mask = 4'b0100;
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        pulse_frame(4'b1100);
        wait_grant(4'b0100, "to_wait");
        measure_hold(4'b0100, hold);
        check("to_hold_cycles", hold, TO);
        check("to_err_set", o_timeout_err, 4'b0100);
        wait_idle("to_idle");
        check("to_sb_empty", exp_q.size(), 0);
        never_mask = '0;

        // overrun: frame during GRANT must not relatch pending
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        v0 = n_ovr;
        pulse_frame(4'b0011);
        wait_grant(4'b0001, "ovr_wait");
        req   = 4'b1111;
        frame = 1'b1;
        tick();
        frame = 1'b0;
        check("ovr_pulse", o_overrun, 1);
        check("ovr_grant_held", o_grant, 4'b0001);
        wait_idle("ovr_idle");
        check("ovr_count", n_ovr - v0, 1);
        check("ovr_sb_empty", exp_q.size(), 0);

        // done on the same cycle the counter expires counts as done
        resp_delay = TO - 1;
        exp_q.push_back(4'b0001);
        pulse_frame(4'b0001);
        wait_grant(4'b0001, "same_wait");
        measure_hold(4'b0001, hold);
        check("same_hold_cycles", hold, TO);
        check("same_no_flag", o_timeout_err, 4'b0100);
        wait_idle("same_idle");
        resp_delay = 3;

        // asynchronous reset mid-grant
        never_mask = 4'b0010;
        exp_q.push_back(4'b0010);
        pulse_frame(4'b0010);
        wait_grant(4'b0010, "rst_wait");
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_grant", o_grant, 0);
        check("arst_busy", o_busy, 0);
        check("arst_terr", o_timeout_err, 0);
        check("arst_pulses", {o_cycle_done, o_abort, o_overrun}, 0);
        rst_n = 1'b1;
        never_mask = '0;
        req = 4'b1111;
        seen = 0;
        repeat (6) begin
            tick();
            if (o_grant != '0 || o_busy) seen++;
        end
        check("arst_no_grant_wo_frame", seen, 0);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        pulse_frame(4'b1111);
        wait_idle("arst_idle");
        check("final_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
